hand_bank: RTL and testbench

Parametrised card-hand store for the Baccarat engine, replacing the fixed bank of per-card 4-bit load registers. Holds up to `MAX_CARDS` cards for each of `NUM_HANDS` hands, accepts one dealt card per clock addressed by hand index, and keeps per-hand card count, full flag and a running baccarat score (mod 10). It sits between the card dealer and the scoring/7-segment logic. The controller FSM issues deals by hand index instead of per-slot load strobes.

---
 rtl/hand_pkg.sv | 19 +
 rtl/hand_slot.sv | 55 +++++
 rtl/hand_bank.sv | 74 +++++++
 tb/tb_hand_bank.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hand_pkg.sv
// Shared card types and helpers for the baccarat hand store.
// Card codes: 1..13 = A..K, 0 = empty slot.
package hand_pkg;

  localparam int CARD_W = 4;

  typedef logic [CARD_W-1:0] card_t;

  localparam card_t CARD_EMPTY = card_t'(0);
  localparam card_t CARD_MAX   = card_t'(13);

  // Baccarat value: pips count face value, tens and courts count zero.
  function automatic logic [3:0] card_value(card_t c);
    if (c >= card_t'(1) && c <= card_t'(9))
      return 4'(c);
    return 4'd0;
  endfunction

endpackage

// File: rtl/hand_slot.sv
// One hand: slot registers, card count and running score mod 10.
// Updates on the falling edge of slow_clock.
module hand_slot #(
  parameter int MAX_CARDS = 3,
  parameter int CARD_W    = 4,
  parameter int CW        = $clog2(MAX_CARDS + 1)
) (
  input  logic                        slow_clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [CARD_W-1:0]           card_in,
  output logic [MAX_CARDS*CARD_W-1:0] cards,
  output logic [CW-1:0]               count,
  output logic [3:0]                  score,
  output logic                        full
);
  import hand_pkg::*;

  logic [MAX_CARDS-1:0][CARD_W-1:0] slot_q;
  logic [CW-1:0]                    count_q;
  logic [3:0]                       score_q;
  logic [4:0]                       sum;
  logic [3:0]                       score_d;

  always_comb begin
    sum     = {1'b0, score_q} + {1'b0, card_value(card_t'(card_in))};
    score_d = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
  end

  always_ff @(negedge slow_clock or posedge reset) begin
    if (reset) begin
      slot_q  <= '0;
      count_q <= '0;
      score_q <= '0;
    end else if (clear) begin
      slot_q  <= '0;
      count_q <= '0;
      score_q <= '0;
    end else if (wr_en) begin
      for (int s = 0; s < MAX_CARDS; s++) begin
        if (count_q == CW'(s))
          slot_q[s] <= card_in;
      end
      count_q <= count_q + CW'(1);
      score_q <= score_d;
    end
  end

  assign cards = slot_q;
  assign count = count_q;
  assign score = score_q;
  assign full  = (count_q == CW'(MAX_CARDS));

endmodule

// File: rtl/hand_bank.sv
// Bank of baccarat hands fed one dealt card per falling edge.
// Illegal deals are dropped and flagged on deal_err the next cycle.
module hand_bank #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  parameter int CARD_W    = hand_pkg::CARD_W,
  localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int CW = $clog2(MAX_CARDS + 1)
) (
  input  logic                                  slow_clock,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  deal_valid,
  input  logic [HW-1:0]                         deal_hand,
  input  logic [CARD_W-1:0]                     card_in,
  output logic [NUM_HANDS*MAX_CARDS*CARD_W-1:0] cards_out,
  output logic [NUM_HANDS*CW-1:0]               count_out,
  output logic [NUM_HANDS*4-1:0]                score_out,
  output logic [NUM_HANDS-1:0]                  full_out,
  output logic                                  deal_err
);
  import hand_pkg::*;

  logic [NUM_HANDS-1:0] wr_en;
  logic [NUM_HANDS-1:0] full;
  logic                 hand_ok;
  logic                 card_ok;
  logic                 sel_full;
  logic                 accept;

  always_comb begin
    hand_ok  = ({1'b0, deal_hand} < (HW+1)'(NUM_HANDS));
    card_ok  = (card_in != '0) && (card_in <= CARD_W'(CARD_MAX));
    sel_full = 1'b0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (deal_hand == HW'(h))
        sel_full = full[h];
    end
    // clear outranks a same-edge deal, so it is never counted as rejected
    accept = deal_valid && !clear && hand_ok && card_ok && !sel_full;
    for (int h = 0; h < NUM_HANDS; h++)
      wr_en[h] = accept && (deal_hand == HW'(h));
  end

  always_ff @(negedge slow_clock or posedge reset) begin
    if (reset)
      deal_err <= 1'b0;
    else if (clear)
      deal_err <= 1'b0;
    else
      deal_err <= deal_valid && !accept;
  end

  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
    hand_slot #(
      .MAX_CARDS(MAX_CARDS),
      .CARD_W   (CARD_W),
      .CW       (CW)
    ) u_slot (
      .slow_clock(slow_clock),
      .reset     (reset),
      .clear     (clear),
      .wr_en     (wr_en[h]),
      .card_in   (card_in),
      .cards     (cards_out[h*MAX_CARDS*CARD_W +: MAX_CARDS*CARD_W]),
      .count     (count_out[h*CW +: CW]),
      .score     (score_out[h*4 +: 4]),
      .full      (full[h])
    );
  end

  assign full_out = full;

endmodule

// File: tb/tb_hand_bank.sv
// Scoreboard bench for hand_bank: a 3x3 build for directed cases
// and a 4x5 build for a randomized sweep against a hand-list model.
module tb_hand_bank;

  logic slow_clock = 1'b1;
  logic reset      = 1'b1;
  always #5 slow_clock = ~slow_clock;

  logic        clear_a = 0, dv_a = 0;
  logic [1:0]  dh_a = 0;
  logic [3:0]  ci_a = 0;
  logic [35:0] cards_a;
  logic [5:0]  count_a;
  logic [11:0] score_a;
  logic [2:0]  full_a;
  logic        err_a;

  logic        clear_b = 0, dv_b = 0;
  logic [1:0]  dh_b = 0;
  logic [3:0]  ci_b = 0;
  logic [79:0] cards_b;
  logic [11:0] count_b;
  logic [15:0] score_b;
  logic [3:0]  full_b;
  logic        err_b;

  hand_bank #(.NUM_HANDS(3), .MAX_CARDS(3)) dut_a (
    .slow_clock(slow_clock), .reset(reset), .clear(clear_a),
    .deal_valid(dv_a), .deal_hand(dh_a), .card_in(ci_a),
    .cards_out(cards_a), .count_out(count_a), .score_out(score_a),
    .full_out(full_a), .deal_err(err_a)
  );

  hand_bank #(.NUM_HANDS(4), .MAX_CARDS(5)) dut_b (
    .slow_clock(slow_clock), .reset(reset), .clear(clear_b),
    .deal_valid(dv_b), .deal_hand(dh_b), .card_in(ci_b),
    .cards_out(cards_b), .count_out(count_b), .score_out(score_b),
    .full_out(full_b), .deal_err(err_b)
  );

  typedef struct {
    logic [127:0] cards;
    logic [15:0]  count;
    logic [15:0]  score;
    logic [3:0]   full;
    logic         err;
  } snap_t;

  snap_t qa[$];
  snap_t qb[$];
  int    hq[2][4][$];
  int    checks = 0;
  int    errors = 0;

  function automatic snap_t expect_of(int d, logic e);
    snap_t x;
    int nh = (d != 0) ? 4 : 3;
    int mc = (d != 0) ? 5 : 3;
    int cw = (d != 0) ? 3 : 2;
    x.cards = '0; x.count = '0; x.score = '0; x.full = '0; x.err = e;
    for (int h = 0; h < nh; h++) begin
      int n = hq[d][h].size();
      int sum = 0;
      for (int s = 0; s < n; s++) begin
        x.cards |= 128'(hq[d][h][s]) << ((h*mc + s)*4);
        sum += (hq[d][h][s] <= 9) ? hq[d][h][s] : 0;
      end
      x.count |= 16'(n) << (h*cw);
      x.score |= 16'(sum % 10) << (h*4);
      x.full[h] = (n == mc);
    end
    return x;
  endfunction

  function automatic snap_t actual(int d);
    snap_t x;
    if (d == 0) begin
      x.cards = 128'(cards_a); x.count = 16'(count_a);
      x.score = 16'(score_a);  x.full = 4'(full_a); x.err = err_a;
    end else begin
      x.cards = 128'(cards_b); x.count = 16'(count_b);
      x.score = 16'(score_b);  x.full = full_b;     x.err = err_b;
    end
    return x;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare(string tag, snap_t a, snap_t e);
    chk({tag, ".cards"}, a.cards, e.cards);
    chk({tag, ".count"}, 128'(a.count), 128'(e.count));
    chk({tag, ".score"}, 128'(a.score), 128'(e.score));
    chk({tag, ".full"},  128'(a.full),  128'(e.full));
    chk({tag, ".err"},   128'(a.err),   128'(e.err));
  endtask

  // Monitor: each expectation covers the falling edge just before this rising edge
  always @(posedge slow_clock) begin
    if (qa.size() > 0) compare("a", actual(0), qa.pop_front());
    if (qb.size() > 0) compare("b", actual(1), qb.pop_front());
  end

  task automatic idle_all();
    clear_a = 0; dv_a = 0; dh_a = 0; ci_a = 0;
    clear_b = 0; dv_b = 0; dh_b = 0; ci_b = 0;
  endtask

  task automatic model_clear(int d);
    for (int h = 0; h < 4; h++) hq[d][h].delete();
  endtask

  task automatic step(int d, logic clr, logic v, logic [1:0] h, logic [3:0] c);
    logic e;
    int nh, mc;
    @(posedge slow_clock);
    #1;
    idle_all();
    if (d == 0) begin
      clear_a = clr; dv_a = v; dh_a = h; ci_a = c;
    end else begin
      clear_b = clr; dv_b = v; dh_b = h; ci_b = c;
    end
    nh = (d != 0) ? 4 : 3;
    mc = (d != 0) ? 5 : 3;
    e  = 1'b0;
    if (clr) begin
      model_clear(d);
    end else if (v) begin
      if (int'(h) < nh && c >= 1 && c <= 13 && hq[d][int'(h)].size() < mc)
        hq[d][int'(h)].push_back(int'(c));
      else
        e = 1'b1;
    end
    if (d == 0) qa.push_back(expect_of(0, e));
    else        qb.push_back(expect_of(1, e));
  endtask

  task automatic async_reset();
    @(posedge slow_clock);
    #1;
    idle_all();
    reset = 1'b1;
    model_clear(0);
    model_clear(1);
    #1;
    compare("rst_a", actual(0), expect_of(0, 1'b0));
    compare("rst_b", actual(1), expect_of(1, 1'b0));
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int r, cr;
    logic [3:0] card;
    #2;
    compare("por_a", actual(0), expect_of(0, 1'b0));
    compare("por_b", actual(1), expect_of(1, 1'b0));
    @(posedge slow_clock);
    #1 reset = 1'b0;

    step(0, 0, 1, 1, 3);
    step(0, 0, 1, 2, 8);
    async_reset();
    step(0, 0, 1, 0, 7);
    step(0, 0, 1, 0, 13);
    step(0, 0, 1, 0, 5);
    step(0, 0, 1, 0, 9);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 14);
    step(0, 0, 1, 3, 6);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 9);
    step(0, 0, 1, 2, 9);
    step(0, 1, 1, 1, 4);
    step(0, 0, 1, 1, 4);
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        async_reset();
      end else begin
        cr = $urandom_range(0, 99);
        if (cr < 85) card = 4'($urandom_range(1, 13));
        else if (cr < 93) card = 4'd0;
        else card = 4'($urandom_range(14, 15));
        step(1, r < 4, r < 85, 2'($urandom_range(0, 3)), card);
      end
    end
    step(1, 0, 0, 0, 0);

    @(posedge slow_clock);
    #1 idle_all();
    @(posedge slow_clock);
    @(posedge slow_clock);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending a=%0d b=%0d required 0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
